mem_access_sequencer: RTL and testbench

Sequences the single-port 16-bit-address, 32-bit-data RAM between two requesters: instruction fetch and the LDR/STR data path.
- Arbitrates each access, drives registered RAM control, waits out the RAM read latency and returns a one-cycle acknowledge with the read data.
- Replaces the ad-hoc address-select / RW muxing with an explicit handshake, so fetch stalls cleanly while a load or store owns the RAM.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_access_sequencer.sv | 152 +++++++++++++++
 tb/tb_mem_access_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the RAM access sequencer and the LDR/STR decode that feeds it.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } mas_state_e;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;

endpackage

// File: rtl/mem_access_sequencer.sv
// Arbitrates instruction fetch and LDR/STR accesses onto a single-port RAM with registered
// control, fixed read latency and a one-cycle acknowledge per access.
module mem_access_sequencer
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              owner,
  output logic              busy
);

  localparam logic [3:0] StreakMax = 4'(MAX_STREAK);
  localparam logic [2:0] LatInit   = 3'(RAM_LAT);

  mas_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] fetch_rdata_q, fetch_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic [3:0]        streak_q, streak_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic              fetch_starved;

  // Fetch has waited out MAX_STREAK data grants and must win this round.
  assign fetch_starved = fetch_req && (streak_q == StreakMax);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ram_en_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    fetch_rdata_d = fetch_rdata_q;
    data_rdata_d  = data_rdata_q;
    streak_d      = streak_q;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (!fetch_req) begin
          streak_d = '0;
        end
        if (data_req && !fetch_starved) begin
          owner_d     = OWN_DATA;
          ram_en_d    = 1'b1;
          ram_we_d    = data_we;
          ram_addr_d  = data_addr;
          ram_wdata_d = data_wdata;
          state_d     = StIssue;
          if (fetch_req) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (fetch_req) begin
          owner_d    = OWN_FETCH;
          ram_en_d   = 1'b1;
          ram_addr_d = fetch_addr;
          streak_d   = '0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (ram_we_q) begin
          state_d = StResp;
        end else begin
          wait_cnt_d = LatInit;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (wait_cnt_q == 3'd1) begin
          wait_cnt_d = '0;
          state_d    = StResp;
          if (owner_q == OWN_DATA) begin
            data_rdata_d = ram_rdata;
          end else begin
            fetch_rdata_d = ram_rdata;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      owner_q       <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
      streak_q      <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
      streak_q      <= streak_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign fetch_ack   = (state_q == StResp) && (owner_q == OWN_FETCH);
  assign data_ack    = (state_q == StResp) && (owner_q == OWN_DATA);
  assign fetch_rdata = fetch_rdata_q;
  assign data_rdata  = data_rdata_q;
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign owner       = owner_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed vectors, multi-cycle corner sequences and a random
// run against a transaction-level model with its own memory image.
module tb_mem_access_sequencer;

  localparam int MaxStreak = 4;

  logic        clock;
  logic        reset_n;
  logic        fetch_req, data_req, data_we;
  logic [15:0] fetch_addr, data_addr;
  logic [31:0] data_wdata;
  logic        fetch_ack, data_ack, ram_en, ram_we, owner, busy;
  logic [31:0] fetch_rdata, data_rdata, ram_wdata, ram_rdata;
  logic [15:0] ram_addr;

  logic        f3_req;
  logic [15:0] f3_addr;
  logic        fetch_ack3, data_ack3, ram_en3, ram_we3, owner3, busy3;
  logic [31:0] fetch_rdata3, data_rdata3, ram_wdata3, ram_rdata3;
  logic [15:0] ram_addr3;

  mem_access_sequencer #(.ADDR_W(16), .DATA_W(32), .RAM_LAT(1), .MAX_STREAK(MaxStreak)) dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_rdata(data_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .owner(owner), .busy(busy)
  );

  mem_access_sequencer #(.ADDR_W(16), .DATA_W(32), .RAM_LAT(3), .MAX_STREAK(MaxStreak)) dut3 (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(f3_req), .fetch_addr(f3_addr), .fetch_ack(fetch_ack3),
    .fetch_rdata(fetch_rdata3),
    .data_req(1'b0), .data_we(1'b0), .data_addr(16'h0000), .data_wdata(32'h0),
    .data_ack(data_ack3), .data_rdata(data_rdata3),
    .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
    .ram_rdata(ram_rdata3), .owner(owner3), .busy(busy3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  // Environment RAM, latency 1: read data valid only in the cycle after the ram_en cycle.
  logic [31:0] ram_mem   [0:65535];
  bit          ram_valid [0:65535];
  always @(posedge clock) begin
    ram_rdata <= 32'h0BAD0BAD;
    if (ram_en) begin
      if (ram_we) begin
        ram_mem[ram_addr]   <= ram_wdata;
        ram_valid[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= ram_valid[ram_addr] ? ram_mem[ram_addr] : init_word(ram_addr);
      end
    end
  end

  // Read-only environment RAM, latency 3.
  logic [31:0] p3_0, p3_1, p3_2;
  always @(posedge clock) begin
    p3_0 <= (ram_en3 && !ram_we3) ? init_word(ram_addr3) : 32'h0BAD0BAD;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign ram_rdata3 = p3_2;

  // Reference memory image, updated when the model grants a write.
  logic [31:0] ref_mem   [0:65535];
  bit          ref_valid [0:65535];

  function automatic logic [31:0] ref_read(input logic [15:0] a);
    return ref_valid[a] ? ref_mem[a] : init_word(a);
  endfunction

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic data_access(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                             output int lat, output int en_cyc, output logic en_we,
                             output logic [15:0] en_addr, output logic [31:0] en_wd,
                             output logic [31:0] rd);
    data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wd;
    lat = -1; en_cyc = -1; en_we = 1'b0; en_addr = '0; en_wd = '0; rd = '0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      if (ram_en && en_cyc < 0) begin
        en_cyc = c; en_we = ram_we; en_addr = ram_addr; en_wd = ram_wdata;
      end
      if (data_ack) begin
        lat = c; rd = data_rdata; data_req = 1'b0;
      end
    end
    data_req = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  int          lat, en_cyc, d_cyc, f_cyc, n_seen, n_data_first;
  logic        en_we;
  logic [15:0] en_addr;
  logic [31:0] en_wd, rd, f_rd;
  int          seq [$];
  int          t, free_at, grant_t, exp_ack_t, streak_m;
  logic        m_own, m_we;
  logic [15:0] m_addr;
  logic [31:0] m_wd, m_rd;

  initial begin
    reset_n = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    f3_req = 1'b0; f3_addr = '0;

    vecs[0] = '{1'b1, 16'h0040, 32'hDEADBEEF, 2, 32'h0};
    vecs[1] = '{1'b0, 16'h0040, 32'h0,        3, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 16'h0044, 32'h12345678, 2, 32'h0};
    vecs[3] = '{1'b0, 16'h0044, 32'h0,        3, 32'h12345678};
    vecs[4] = '{1'b0, 16'h0048, 32'h0,        3, init_word(16'h0048)};
    vecs[5] = '{1'b1, 16'h0000, 32'hCAFEF00D, 2, 32'h0};
    vecs[6] = '{1'b0, 16'h0000, 32'h0,        3, 32'hCAFEF00D};

    repeat (3) tick();
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_acks", {fetch_ack, data_ack}, 0);
    check("rst_rdata", fetch_rdata | data_rdata, 0);
    check("rst_owner_busy", {owner, busy}, 0);
    reset_n = 1'b1;
    tick();

    // Directed single-access vectors.
    for (int i = 0; i < 7; i++) begin
      data_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, en_cyc, en_we, en_addr, en_wd,
                  rd);
      if (vecs[i].we) begin
        ref_mem[vecs[i].addr] = vecs[i].wdata;
        ref_valid[vecs[i].addr] = 1'b1;
      end
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_en_cyc", i), en_cyc, 1);
      check($sformatf("vec%0d_ram_we", i), en_we, vecs[i].we);
      check($sformatf("vec%0d_ram_addr", i), en_addr, vecs[i].addr);
      if (vecs[i].we) check($sformatf("vec%0d_ram_wdata", i), en_wd, vecs[i].wdata);
      else            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Reset while a read sits in WAIT drops the access.
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0040;
    tick();
    tick();
    reset_n = 1'b0; data_req = 1'b0;
    tick();
    tick();
    check("midrst_ram", {ram_en, ram_we, ram_addr, ram_wdata[14:0]}, 0);
    check("midrst_ram_wdata", ram_wdata, 0);
    check("midrst_rdata", fetch_rdata | data_rdata, 0);
    check("midrst_flags", {fetch_ack, data_ack, owner, busy}, 0);
    reset_n = 1'b1;
    n_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (fetch_ack || data_ack || ram_en || busy) n_seen++;
    end
    check("midrst_quiet", n_seen, 0);

    // Simultaneous requests: data first, fetch follows.
    fetch_req = 1'b1; fetch_addr = 16'h0000;
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0044;
    d_cyc = -1; f_cyc = -1; f_rd = '0;
    for (int c = 1; c <= 30 && (d_cyc < 0 || f_cyc < 0); c++) begin
      tick();
      if (data_ack) begin d_cyc = c; data_req = 1'b0; end
      if (fetch_ack) begin f_cyc = c; f_rd = fetch_rdata; fetch_req = 1'b0; end
    end
    data_req = 1'b0; fetch_req = 1'b0;
    tick();
    check("simul_data_ack_cyc", d_cyc, 3);
    check("simul_fetch_ack_cyc", f_cyc, 7);
    check("simul_fetch_rdata", f_rd, ref_read(16'h0000));

    // Starvation guard: continuous data reads with fetch pending.
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0044;
    fetch_req = 1'b1; fetch_addr = 16'h0040;
    seq.delete();
    f_rd = '0;
    for (int c = 1; c <= 60 && seq.size() < 7; c++) begin
      tick();
      if (data_ack) seq.push_back(1);
      if (fetch_ack) begin seq.push_back(0); f_rd = fetch_rdata; fetch_req = 1'b0; end
      if (seq.size() >= 7) data_req = 1'b0;
    end
    data_req = 1'b0; fetch_req = 1'b0;
    tick();
    check("starve_ack_count", seq.size(), 7);
    n_data_first = 0;
    while (n_data_first < seq.size() && seq[n_data_first] == 1) n_data_first++;
    check("starve_data_before_fetch", n_data_first, MaxStreak);
    check("starve_fetch_rdata", f_rd, ref_read(16'h0040));
    if (seq.size() == 7) begin
      check("starve_resume5", seq[5], 1);
      check("starve_resume6", seq[6], 1);
    end

    // Latency-3 fetch; address change after grant must be ignored.
    f3_req = 1'b1; f3_addr = 16'h1234;
    f_cyc = -1; en_cyc = -1; en_addr = '0; f_rd = '0; n_seen = 0;
    for (int c = 1; c <= 20 && f_cyc < 0; c++) begin
      tick();
      if (c == 1) f3_addr = 16'h5678;
      if (ram_en3) begin n_seen++; if (en_cyc < 0) begin en_cyc = c; en_addr = ram_addr3; end end
      if (data_ack3) n_seen += 100;
      if (fetch_ack3) begin f_cyc = c; f_rd = fetch_rdata3; f3_req = 1'b0; end
    end
    f3_req = 1'b0;
    tick();
    check("lat3_ack_cyc", f_cyc, 5);
    check("lat3_en_cyc", en_cyc, 1);
    check("lat3_en_once", n_seen, 1);
    check("lat3_ram_addr", en_addr, 16'h1234);
    check("lat3_rdata", f_rd, init_word(16'h1234));

    // Random run against the transaction model.
    t = 0; free_at = 0; grant_t = -10; exp_ack_t = -10; streak_m = 0;
    m_own = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0; m_rd = '0;
    for (int n = 0; n < 1500; n++) begin
      tick();
      t++;
      check("r_ram_en", ram_en, (t == grant_t + 1));
      check("r_we_implies_en", ram_we && !ram_en, 0);
      if (t == grant_t + 1) begin
        check("r_ram_we", ram_we, m_we);
        check("r_ram_addr", ram_addr, m_addr);
        if (m_we) check("r_ram_wdata", ram_wdata, m_wd);
      end
      check("r_fetch_ack", fetch_ack, (t == exp_ack_t) && !m_own);
      check("r_data_ack", data_ack, (t == exp_ack_t) && m_own);
      check("r_busy", busy, (t > grant_t) && (t <= exp_ack_t));
      if (t > grant_t && grant_t >= 0) check("r_owner", owner, m_own);
      if (t == exp_ack_t) begin
        if (!m_we) check("r_rdata", m_own ? data_rdata : fetch_rdata, m_rd);
        if (m_own) data_req = 1'b0;
        else       fetch_req = 1'b0;
      end
      if (!fetch_req && $urandom_range(0, 99) < 40) begin
        fetch_req = 1'b1;
        fetch_addr = 16'($urandom_range(0, 7) * 4);
      end
      if (!data_req && $urandom_range(0, 99) < 70) begin
        data_req = 1'b1;
        data_we = 1'($urandom_range(0, 1));
        data_addr = 16'($urandom_range(0, 7) * 4);
        data_wdata = $urandom;
      end
      if (t >= free_at) begin
        if (data_req && !(fetch_req && streak_m == MaxStreak)) begin
          m_own = 1'b1; m_we = data_we; m_addr = data_addr; m_wd = data_wdata;
          streak_m = fetch_req ? streak_m + 1 : 0;
          grant_t = t;
        end else if (fetch_req) begin
          m_own = 1'b0; m_we = 1'b0; m_addr = fetch_addr;
          streak_m = 0;
          grant_t = t;
        end else begin
          streak_m = 0;
        end
        if (grant_t == t) begin
          exp_ack_t = t + 2 + (m_we ? 0 : 1);
          free_at = exp_ack_t + 1;
          if (m_we) begin
            ref_mem[m_addr] = m_wd;
            ref_valid[m_addr] = 1'b1;
          end else begin
            m_rd = ref_read(m_addr);
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
